// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for a MIPS-subset CPU (R-type, ADDI, SLTI, LW,
// SW, BEQ). Sequences a shared ALU and a shared memory port through
// IF/ID/EX/MEM/WB steps, counts retired instructions, and halts in TRAP on an
// illegal opcode or a memory access that never completes.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   instr_op_i   [5:0]  opcode field of the instruction register (valid in ID)
//   mem_ready_i         memory completes the current access this cycle
//   PCWrite_o .. ALU_op_o   datapath control (all 0 while rst_i=1)
//   state_o      [3:0]  current state encoding (debug)
//   retire_cnt_o        instructions retired since reset (wraps)
//   trap_o              sticky halt flag, set the cycle after TRAP is entered
//   trap_cause_o [1:0]  01 illegal opcode, 10 memory timeout, 00 none
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             RegDst_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [7:0]       ALU_op_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MRD  = 4'd3,
    S_MWR  = 4'd4,
    S_WBA  = 4'd5,
    S_WBM  = 4'd6,
    S_BR   = 4'd7,
    S_TRAP = 4'd8
  } state_t;

  state_t             state, state_nx;
  logic [5:0]         op_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   retire_cnt;
  logic               trap;
  logic [1:0]         cause, cause_nx;
  logic               timeout;
  logic               in_wait;
  logic               retire;

  assign timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign in_wait = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
  assign retire  = (state_nx == S_IF) &&
                   ((state == S_MWR) || (state == S_WBA) ||
                    (state == S_WBM) || (state == S_BR));

  always_comb begin
    state_nx      = state;
    cause_nx      = cause;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    RegDst_o      = 1'b0;
    MemtoReg_o    = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALU_op_o      = 8'h00;

    case (state)
      S_IF: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        ALU_op_o  = 8'h08;
        // mem_ready_i beats the timeout when both occur in the same cycle
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_nx  = S_ID;
        end else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = 2'b10;
        end
      end
      S_ID: begin
        ALUSrcB_o = 2'b11;
        ALU_op_o  = 8'h08;
        case (instr_op_i)
          OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW: state_nx = S_EX;
          OP_BEQ:  state_nx = S_BR;
          default: begin
            state_nx = S_TRAP;
            cause_nx = 2'b01;
          end
        endcase
      end
      S_EX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = (op_q == OP_RTYPE) ? 2'b00 : 2'b10;
        ALU_op_o  = {2'b00, op_q};
        if (op_q == OP_LW)      state_nx = S_MRD;
        else if (op_q == OP_SW) state_nx = S_MWR;
        else                    state_nx = S_WBA;
      end
      S_MRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) begin
          state_nx = S_WBM;
        end else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = 2'b10;
        end
      end
      S_MWR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) begin
          state_nx = S_IF;
        end else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = 2'b10;
        end
      end
      S_WBA: begin
        RegWrite_o = 1'b1;
        RegDst_o   = (op_q == OP_RTYPE);
        state_nx   = S_IF;
      end
      S_WBM: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        state_nx   = S_IF;
      end
      S_BR: begin
        ALUSrcA_o     = 1'b1;
        ALU_op_o      = 8'h04;
        PCWriteCond_o = 1'b1;
        state_nx      = S_IF;
      end
      S_TRAP: state_nx = S_TRAP;
      default: begin
        state_nx = S_TRAP;
        cause_nx = cause;
      end
    endcase

    // Controls are forced low combinationally so nothing reaches the datapath
    // during the reset cycle, regardless of the state being left.
    if (rst_i) begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      RegDst_o      = 1'b0;
      MemtoReg_o    = 1'b0;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'b00;
      ALU_op_o      = 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IF;
      op_q       <= '0;
      wait_cnt   <= '0;
      retire_cnt <= '0;
      trap       <= 1'b0;
      cause      <= 2'b00;
    end else begin
      state <= state_nx;
      cause <= cause_nx;
      if (state == S_ID) op_q <= instr_op_i;
      // Any state change clears the counter, so it starts at 0 in each wait state
      if (state_nx != state)  wait_cnt <= '0;
      else if (in_wait)       wait_cnt <= wait_cnt + 1'b1;
      if (retire)             retire_cnt <= retire_cnt + 1'b1;
      if (state == S_TRAP)    trap <= 1'b1;
    end
  end

  assign state_o      = state;
  assign retire_cnt_o = retire_cnt;
  assign trap_o       = trap;
  assign trap_cause_o = cause;

endmodule
